// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - right-to-left square-and-multiply sequencer driving one modmult unit
//
// Computes result = base^exponent mod modulus by issuing one multiplication
// at a time to an external modmult datapath.
//
// Ports:
//   clk, reset          clock (rising edge) and synchronous active-low reset
//   start               request strobe, sampled only while idle
//   base/exponent/modulus  request operands, latched on an accepted start
//   busy                high from the cycle after an accepted start until done
//   done                one-cycle pulse, result valid in the same cycle
//   result              final value, held until the next accepted start
//   mm_mpand/mm_mplier/mm_modulus  modmult operands, stable until the product returns
//   mm_ds               modmult start strobe, one cycle per multiplication
//   mm_ready/mm_product modmult completion level and product
module modexp_ctrl #(
  parameter int MPWID = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [MPWID-1:0] base,
  input  logic [MPWID-1:0] exponent,
  input  logic [MPWID-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [MPWID-1:0] result,
  output logic [MPWID-1:0] mm_mpand,
  output logic [MPWID-1:0] mm_mplier,
  output logic [MPWID-1:0] mm_modulus,
  output logic             mm_ds,
  input  logic             mm_ready,
  input  logic [MPWID-1:0] mm_product
);

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    MUL_ISSUE,
    MUL_GUARD,
    MUL_WAIT,
    SQR_ISSUE,
    SQR_GUARD,
    SQR_WAIT,
    FINISH
  } state_t;

  localparam logic [MPWID-1:0] ONE = {{(MPWID-1){1'b0}}, 1'b1};

  state_t           state;
  logic [MPWID-1:0] acc;  // running result
  logic [MPWID-1:0] sq;   // running square of base
  logic [MPWID-1:0] e;    // remaining exponent bits, consumed LSB first
  logic [MPWID-1:0] m;    // latched modulus

  // Outputs are registered: every transition into an ISSUE state loads the
  // operands and raises mm_ds together, and every transition into FINISH
  // loads result and raises done, so both are valid during that state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      sq         <= '0;
      e          <= '0;
      m          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mm_mpand   <= '0;
      mm_mplier  <= '0;
      mm_modulus <= '0;
      mm_ds      <= 1'b0;
    end else begin
      mm_ds <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= ONE;
            sq    <= base;
            e     <= exponent;
            m     <= modulus;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (e == '0) begin
            result <= acc;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FINISH;
          end else if (e[0]) begin
            mm_mpand   <= acc;
            mm_mplier  <= sq;
            mm_modulus <= m;
            mm_ds      <= 1'b1;
            state      <= MUL_ISSUE;
          end else begin
            mm_mpand   <= sq;
            mm_mplier  <= sq;
            mm_modulus <= m;
            mm_ds      <= 1'b1;
            state      <= SQR_ISSUE;
          end
        end

        MUL_ISSUE: state <= MUL_GUARD;

        // mm_ready may still show the previous product here; it is not trusted.
        MUL_GUARD: state <= MUL_WAIT;

        MUL_WAIT: begin
          if (mm_ready) begin
            acc <= mm_product;
            if (e[MPWID-1:1] == '0) begin
              // Last set bit consumed: the trailing square would be unused.
              result <= mm_product;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= FINISH;
            end else begin
              mm_mpand   <= sq;
              mm_mplier  <= sq;
              mm_modulus <= m;
              mm_ds      <= 1'b1;
              state      <= SQR_ISSUE;
            end
          end
        end

        SQR_ISSUE: state <= SQR_GUARD;

        SQR_GUARD: state <= SQR_WAIT;

        SQR_WAIT: begin
          if (mm_ready) begin
            sq <= mm_product;
            e  <= e >> 1;
            if (e[MPWID-1:1] == '0) begin
              result <= acc;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= FINISH;
            end else begin
              state <= CHECK;
            end
          end
        end

        FINISH: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - self-checking bench for modexp_ctrl with a random-latency modmult model
//
// Drives modexp_ctrl requests, models the modmult datapath with 3..40 cycle
// latency, and compares results popped from an expected-value queue.
// Ports: none (top-level bench).
module tb_modexp_ctrl;

  localparam int MPWID = 32;

  logic             clk;
  logic             reset;
  logic             start;
  logic [MPWID-1:0] base;
  logic [MPWID-1:0] exponent;
  logic [MPWID-1:0] modulus;
  logic             busy;
  logic             done;
  logic [MPWID-1:0] result;
  logic [MPWID-1:0] mm_mpand;
  logic [MPWID-1:0] mm_mplier;
  logic [MPWID-1:0] mm_modulus;
  logic             mm_ds;
  logic             mm_ready;
  logic [MPWID-1:0] mm_product;

  int errors;
  int checks;

  logic [MPWID-1:0] exp_q[$];

  modexp_ctrl #(.MPWID(MPWID)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .exponent   (exponent),
    .modulus    (modulus),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mm_mpand   (mm_mpand),
    .mm_mplier  (mm_mplier),
    .mm_modulus (mm_modulus),
    .mm_ds      (mm_ds),
    .mm_ready   (mm_ready),
    .mm_product (mm_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // modmult model plus strobe/done monitors
  int               lat_cnt = 0;
  bit               drop_pend = 0;
  logic [MPWID-1:0] pend_prod;
  int               ds_count = 0;
  int               done_count = 0;
  int               consec_err = 0;
  bit               ds_prev = 0;
  logic [MPWID-1:0] last_mpand, last_mplier, last_mod;

  initial begin
    mm_ready   = 1'b0;
    mm_product = '0;
  end

  always @(posedge clk) begin
    if (lat_cnt > 0) begin
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        mm_ready   <= 1'b1;
        mm_product <= pend_prod;
      end
    end
    if (drop_pend) begin
      mm_ready <= 1'b0;
      drop_pend = 0;
    end
    if (mm_ds === 1'b1) begin
      pend_prod   = MPWID'((64'(mm_mpand) * 64'(mm_mplier)) % 64'(mm_modulus));
      lat_cnt     = $urandom_range(3, 40);
      drop_pend   = 1;
      ds_count    = ds_count + 1;
      last_mpand  = mm_mpand;
      last_mplier = mm_mplier;
      last_mod    = mm_modulus;
      if (ds_prev) consec_err = consec_err + 1;
    end
    ds_prev = (mm_ds === 1'b1);
    if (done === 1'b1) done_count = done_count + 1;
  end

  // Reference by plain repeated multiplication (small exponents only).
  function automatic logic [MPWID-1:0] ref_modexp(input logic [MPWID-1:0] b,
                                                   input logic [MPWID-1:0] ex,
                                                   input logic [MPWID-1:0] md);
    longint unsigned r;
    r = 64'd1 % 64'(md);
    for (int i = 0; i < int'(ex); i++) r = (r * 64'(b)) % 64'(md);
    return MPWID'(r);
  endfunction

  // Issues one request and runs until done; returns with the bench at the
  // negedge of the done cycle so a following request lands in the next IDLE.
  task automatic run_op(input logic [MPWID-1:0] b, input logic [MPWID-1:0] ex,
                        input logic [MPWID-1:0] md, input bit inject,
                        output int ds_n, output int lat);
    int  ds0;
    int  cyc;
    bit  got;
    bit  busy_drop;
    logic [MPWID-1:0] expv;
    @(negedge clk);
    base = b; exponent = ex; modulus = md; start = 1'b1;
    exp_q.push_back(ref_modexp(b, ex, md));
    ds0 = ds_count;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
    cyc = 1; got = 0; busy_drop = 0;
    while (!got && cyc < 3000) begin
      if (done === 1'b1) begin
        got = 1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sb_empty: done with no expected result");
        end else begin
          expv = exp_q.pop_front();
          if (result !== expv) begin
            errors++; $display("FAIL result: got %0d want %0d", result, expv);
          end
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL busy_at_done: got %b want 0", busy);
        end
      end else begin
        if (busy !== 1'b1) busy_drop = 1;
        if (inject && cyc == 4) begin
          base = 9; exponent = 3; modulus = 13; start = 1'b1;
        end
        if (inject && cyc == 5) begin
          start = 1'b0; base = b; exponent = ex; modulus = md;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL timeout: no done after %0d cycles want done", cyc);
    end
    checks++;
    if (busy_drop) begin
      errors++; $display("FAIL busy_throughout: got drop want steady 1");
    end
    ds_n = ds_count - ds0;
    lat  = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, mm_ds} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, mm_ds});
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL reset_result: got %0d want 0", result);
    end
    checks++;
    if ({mm_mpand, mm_mplier, mm_modulus} !== '0) begin
      errors++; $display("FAIL reset_operands: got %0d/%0d/%0d want 0", mm_mpand, mm_mplier, mm_modulus);
    end
  endtask

  task automatic test_basic();
    int ds_n, lat, d0;
    d0 = done_count;
    run_op(4, 13, 497, 0, ds_n, lat);
    checks++;
    if (ds_n != 6) begin
      errors++; $display("FAIL basic_ds_count: got %0d want 6", ds_n);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_count - d0 != 1) begin
      errors++; $display("FAIL basic_done_once: got %0d pulses want 1", done_count - d0);
    end
    checks++;
    if (result !== 32'd445) begin
      errors++; $display("FAIL basic_result_hold: got %0d want 445", result);
    end
  endtask

  task automatic test_square_mix();
    int ds_n, lat;
    run_op(2, 10, 1000, 0, ds_n, lat);
    checks++;
    if (ds_n != 5) begin
      errors++; $display("FAIL mix_ds_count: got %0d want 5", ds_n);
    end
  endtask

  task automatic test_exp_zero();
    int ds_n, lat;
    run_op(5, 0, 7, 0, ds_n, lat);
    checks++;
    if (ds_n != 0) begin
      errors++; $display("FAIL zero_ds_count: got %0d want 0", ds_n);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL zero_latency: got %0d want 2 cycles after start cycle", lat);
    end
  endtask

  task automatic test_exp_one();
    int ds_n, lat;
    run_op(7, 1, 11, 0, ds_n, lat);
    checks++;
    if (ds_n != 1) begin
      errors++; $display("FAIL one_ds_count: got %0d want 1", ds_n);
    end
    checks++;
    if (last_mpand !== 32'd1 || last_mplier !== 32'd7 || last_mod !== 32'd11) begin
      errors++; $display("FAIL one_operands: got %0d*%0d mod %0d want 1*7 mod 11", last_mpand, last_mplier, last_mod);
    end
  endtask

  task automatic test_back_to_back();
    int ds_n, lat;
    run_op(4, 13, 497, 1, ds_n, lat);
    checks++;
    if (ds_n != 6) begin
      errors++; $display("FAIL b2b_ds_count: got %0d want 6", ds_n);
    end
    run_op(3, 5, 100, 0, ds_n, lat);
    checks++;
    if (ds_n != 4) begin
      errors++; $display("FAIL b2b_second_ds_count: got %0d want 4", ds_n);
    end
  endtask

  task automatic test_reset_mid();
    int  cyc, d0, ds0, ds_n, lat;
    @(negedge clk);
    base = 4; exponent = 13; modulus = 497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (mm_ds !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (mm_ds !== 1'b1) begin
      errors++; $display("FAIL mid_issue_seen: got %b want 1", mm_ds);
    end
    @(negedge clk);  // guard
    @(negedge clk);  // first wait cycle
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({busy, done, mm_ds} !== 3'b000 || result !== '0) begin
      errors++; $display("FAIL mid_reset_state: got flags %b result %0d want 000 and 0", {busy, done, mm_ds}, result);
    end
    checks++;
    if ({mm_mpand, mm_mplier, mm_modulus} !== '0) begin
      errors++; $display("FAIL mid_reset_operands: got %0d/%0d/%0d want 0", mm_mpand, mm_mplier, mm_modulus);
    end
    d0 = done_count; ds0 = ds_count;
    repeat (50) @(negedge clk);
    checks++;
    if (done_count != d0 || ds_count != ds0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_late_ready: got done %0d ds %0d busy %b want 0 0 0", done_count - d0, ds_count - ds0, busy);
    end
    run_op(2, 10, 1000, 0, ds_n, lat);
    checks++;
    if (ds_n != 5) begin
      errors++; $display("FAIL mid_restart_ds_count: got %0d want 5", ds_n);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_square_mix();
    test_exp_zero();
    test_exp_one();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (consec_err != 0) begin
      errors++; $display("FAIL ds_consecutive: got %0d back-to-back strobes want 0", consec_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modexp_ctrl.md
Name: modexp_ctrl

Overview:
- Sequencer that computes result = base^exponent mod modulus by driving one external modmult instance.
- Uses right-to-left binary square-and-multiply.
- Sits between the RSA top-level request interface and the shared modmult datapath.
- Owns the modmult operand/strobe ports and issues one multiplication at a time.

Parameters:
MPWID, 32, operand/modulus/exponent width in bits (>= 2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  request strobe; sampled only in IDLE
base  input  MPWID  base operand; precondition base < modulus
exponent  input  MPWID  exponent
modulus  input  MPWID  modulus; precondition modulus >= 2
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when result is valid
result  output  MPWID  final value; held stable until next accepted start
mm_mpand  output  MPWID  modmult multiplicand
mm_mplier  output  MPWID  modmult multiplier
mm_modulus  output  MPWID  modmult modulus (latched modulus)
mm_ds  output  1  modmult start strobe, exactly one cycle per multiplication
mm_ready  input  1  modmult completion level; valid product when high
mm_product  input  MPWID  modmult result

Behaviour:
- Reset (reset==0 at a clock edge, in any state, including mid-operation):
  - state=IDLE; busy=0, done=0, mm_ds=0.
  - result=0; mm_mpand, mm_mplier and mm_modulus = 0.
  - Internal registers cleared.
  - Any in-flight modmult product is ignored.
- Internal registers: acc (running result), sq (running square), e (exponent shift register), m (modulus).
- IDLE: on start==1, latch acc=1, sq=base, e=exponent, m=modulus. Next cycle: busy=1, state=CHECK.
  - start in any other state is ignored; there is no queueing.
- CHECK:
  - If e==0: go to FINISH.
  - Else if e[0]==1: go to MUL_ISSUE.
  - Else: go to SQR_ISSUE.
- MUL_ISSUE: mm_mpand=acc, mm_mplier=sq, mm_modulus=m, mm_ds=1 for this cycle only. Go to MUL_GUARD.
- MUL_GUARD: one cycle; mm_ready is ignored (covers ready deassert latency). Go to MUL_WAIT.
- MUL_WAIT: on mm_ready==1, acc=mm_product.
  - Then, if e[MPWID-1:1]==0: go to FINISH (final square skipped).
  - Else: go to SQR_ISSUE.
- SQR_ISSUE: mm_mpand=sq, mm_mplier=sq, mm_modulus=m, mm_ds=1 for one cycle. Go to SQR_GUARD, then SQR_WAIT.
- SQR_WAIT: on mm_ready==1, sq=mm_product and e=e>>1.
  - If the new e==0: go to FINISH.
  - Else: go to CHECK.
- FINISH: result=acc, done=1 for this one cycle, busy=0 in the same cycle. Next state IDLE.
  - A start in the cycle after FINISH is accepted normally.
- Strobe limits: mm_ds is never high in two consecutive cycles. At most one multiplication is outstanding.
- Operand stability: mm_mpand, mm_mplier and mm_modulus hold their values from ISSUE until the matching WAIT completes.
- No timeout: WAIT states stall indefinitely until mm_ready.
- Pulse count: mm_ds pulses = popcount(exponent) + (index of exponent MSB).
  - exponent==0 gives 0 pulses and result=1.
- Out-of-contract inputs (base >= modulus, modulus < 2):
  - result is unspecified.
  - The controller still terminates after the same pulse count.

Test Plan:
1. base=4, exponent=13, modulus=497, modmult model with 3..40-cycle random latency -> result=445, done pulses exactly once, 6 mm_ds pulses, busy high throughout.
2. base=2, exponent=10, modulus=1000 -> result=24, 5 mm_ds pulses (2 multiply, 3 square).
3. exponent=0, base=5, modulus=7 -> no mm_ds pulse; done 3 cycles after start (IDLE, CHECK, FINISH); result=1.
4. base=7, exponent=1, modulus=11 -> result=7, exactly 1 mm_ds pulse with mm_mpand=1, mm_mplier=7; no square issued.
5. During test 1, assert start again while busy with different operands -> ignored; result still 445. Then start immediately after done -> new run accepted.
6. Drive reset=0 for one cycle in MUL_WAIT of test 1 -> next cycle busy=0, done=0, mm_ds=0, result=0; a late mm_ready is ignored. Restart with test 2 operands -> result=24.
